// File: rtl/ccl_packer.sv
// ccl_packer: transmit side of the CCL byte interface.
// Latches a sparse 16-entry code table, compacts the valid entries in order,
// then emits a header byte {3'b000, n} followed by ceil(n/2) payload bytes,
// two codes per byte, high nibble first. No backpressure: the receiver must
// accept one byte per cycle that winc is high.
// The byte output is named byte_o because "byte" is a reserved word.
module ccl_packer #(
   parameter int NCODE = 16,   // table entries; the datapath is sized for 16
   parameter int CW    = 4,    // code width; the datapath is sized for nibbles
   parameter int GAP   = 0     // idle cycles between consecutive output bytes, 0..15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [NCODE*CW-1:0]   code_sq,
   input  logic [NCODE-1:0]      valid_sq,
   output logic                  busy,
   output logic                  winc,
   output logic [7:0]            byte_o,
   output logic                  done,
   output logic [2:0]            state_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COMPACT = 3'd1,
      HDR     = 3'd2,
      GAPW    = 3'd3,
      DATA    = 3'd4,
      FIN     = 3'd5
   } state_t;

   localparam bit       USE_GAP  = (GAP != 0);
   localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

   state_t                state_q, state_d;
   logic [NCODE*CW-1:0]   code_q, code_d;
   logic [NCODE-1:0]      valid_q, valid_d;
   logic [63:0]           list_q, list_d;    // compacted codes, slot i at [4i+3:4i]
   logic [3:0]            idx_q, idx_d;      // table scan position during COMPACT
   logic [4:0]            n_q, n_d;          // number of compacted codes, 0..16
   logic [2:0]            k_q, k_d;          // payload byte index
   logic [3:0]            gap_q, gap_d;      // idle cycles left before the next byte
   logic                  busy_q, busy_d;
   logic                  winc_q, winc_d;
   logic [7:0]            byte_q, byte_d;
   logic                  done_q, done_d;

   // Payload byte k and whether it is the last one of the frame.
   logic [3:0]            hi_nib, lo_nib;
   logic                  last_byte;

   assign hi_nib    = list_q[{k_q, 1'b0, 2'b00} +: 4];
   assign lo_nib    = ({1'b0, k_q, 1'b1} < n_q) ? list_q[{k_q, 1'b1, 2'b00} +: 4] : 4'h0;
   assign last_byte = (({1'b0, k_q, 1'b0} + 5'd2) >= n_q);

   // State register and all registered outputs; reset drops any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         valid_q <= '0;
         list_q  <= '0;
         idx_q   <= '0;
         n_q     <= '0;
         k_q     <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         winc_q  <= 1'b0;
         byte_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         list_q  <= list_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         k_q     <= k_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         winc_q  <= winc_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      list_d  = list_q;
      idx_d   = idx_q;
      n_d     = n_q;
      k_d     = k_q;
      gap_d   = gap_q;
      busy_d  = busy_q;
      winc_d  = 1'b0;
      byte_d  = byte_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (load) begin
               code_d  = code_sq;
               valid_d = valid_sq;
               list_d  = '0;
               idx_d   = '0;
               n_d     = '0;
               busy_d  = 1'b1;
               state_d = COMPACT;
            end
         end

         // One table entry per cycle; valid entries are appended at slot n.
         COMPACT: begin
            if (valid_q[idx_q]) begin
               list_d[{n_q[3:0], 2'b00} +: 4] = code_q[{idx_q, 2'b00} +: 4];
               n_d = n_q + 5'd1;
            end
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
               state_d = HDR;
            end
         end

         HDR: begin
            winc_d = 1'b1;
            byte_d = {3'b000, n_q};
            k_d    = '0;
            if (n_q == 5'd0) begin
               state_d = FIN;
            end else if (USE_GAP) begin
               gap_d   = GAP_LOAD;
               state_d = GAPW;
            end else begin
               state_d = DATA;
            end
         end

         // Idle cycles between bytes: strobe low, previous byte held.
         GAPW: begin
            if (gap_q == 4'd0) begin
               state_d = DATA;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end

         DATA: begin
            winc_d = 1'b1;
            byte_d = {hi_nib, lo_nib};
            if (last_byte) begin
               state_d = FIN;
            end else begin
               k_d = k_q + 3'd1;
               if (USE_GAP) begin
                  gap_d   = GAP_LOAD;
                  state_d = GAPW;
               end else begin
                  state_d = DATA;
               end
            end
         end

         // First edge raises done with busy still high; the second retires the frame.
         FIN: begin
            byte_d = 8'h00;
            if (!done_q) begin
               done_d = 1'b1;
               busy_d = 1'b1;
            end else begin
               done_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            byte_d  = 8'h00;
         end
      endcase
   end

   assign busy    = busy_q;
   assign winc    = winc_q;
   assign byte_o  = byte_q;
   assign done    = done_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_ccl_packer.sv
// Testbench for ccl_packer. Two instances share the stimulus: one with no
// inter-byte gap and one with GAP=2. Every cycle of every frame is compared
// against a cycle timeline built from the stream format rules, and the
// no-gap byte stream is also compared against a table of known frames.
module tb_ccl_packer;

   localparam int GAP2 = 2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [63:0] code_sq;
   logic [15:0] valid_sq;

   logic        busy0, winc0, done0;
   logic [7:0]  byte0;
   logic [2:0]  state0;
   logic        busy2, winc2, done2;
   logic [7:0]  byte2;
   logic [2:0]  state2;

   always #5 clk = ~clk;

   ccl_packer #(.NCODE(16), .CW(4), .GAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load(load), .code_sq(code_sq), .valid_sq(valid_sq),
      .busy(busy0), .winc(winc0), .byte_o(byte0), .done(done0), .state_o(state0)
   );

   ccl_packer #(.NCODE(16), .CW(4), .GAP(GAP2)) dut2 (
      .clk(clk), .rst_n(rst_n), .load(load), .code_sq(code_sq), .valid_sq(valid_sq),
      .busy(busy2), .winc(winc2), .byte_o(byte2), .done(done2), .state_o(state2)
   );

   // ---------------- scoreboard ----------------
   // Expected per-cycle word: {busy, done, winc, byte}
   logic [10:0] exp0_q[$];
   logic [10:0] exp2_q[$];
   logic [7:0]  got0_q[$];
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference model: compact the valid codes, pack bytes, then lay them out in time.
   function automatic void build_exp(input logic [63:0] code, input logic [15:0] valid,
                                     input int gap, input bit sel);
      logic [3:0]  lst[$];
      logic [7:0]  bytes[$];
      logic [7:0]  cur;
      logic [10:0] tl[$];
      int          n;
      for (int i = 0; i < 16; i++)
         if (valid[i]) lst.push_back(code[4*i +: 4]);
      n = lst.size();
      bytes.push_back(8'(n));
      for (int k = 0; 2*k < n; k++)
         bytes.push_back({lst[2*k], (2*k+1 < n) ? lst[2*k+1] : 4'h0});
      for (int t = 0; t <= 16; t++) tl.push_back({1'b1, 1'b0, 1'b0, 8'h00});
      tl.push_back({1'b1, 1'b0, 1'b1, bytes[0]});
      cur = bytes[0];
      for (int b = 1; b < bytes.size(); b++) begin
         for (int g = 0; g < gap; g++) tl.push_back({1'b1, 1'b0, 1'b0, cur});
         tl.push_back({1'b1, 1'b0, 1'b1, bytes[b]});
         cur = bytes[b];
      end
      tl.push_back({1'b1, 1'b1, 1'b0, 8'h00});
      tl.push_back({1'b0, 1'b0, 1'b0, 8'h00});
      foreach (tl[i]) begin
         if (sel) exp2_q.push_back(tl[i]);
         else     exp0_q.push_back(tl[i]);
      end
   endfunction

   // ---------------- driver ----------------
   // Loads one frame, compares both instances every cycle; abort_t>0 pulls reset
   // asynchronously in the middle of that cycle instead.
   task automatic run_frame(input logic [63:0] code, input logic [15:0] valid,
                            input bit mid_load, input int abort_t, output bit aborted);
      int len;
      aborted = 1'b0;
      exp0_q.delete();
      exp2_q.delete();
      got0_q.delete();
      build_exp(code, valid, 0, 1'b0);
      build_exp(code, valid, GAP2, 1'b1);
      while (exp0_q.size() < exp2_q.size()) exp0_q.push_back(11'h0);
      while (exp2_q.size() < exp0_q.size()) exp2_q.push_back(11'h0);
      len = exp0_q.size();
      @(negedge clk);
      code_sq  = code;
      valid_sq = valid;
      load     = 1'b1;
      for (int t = 0; t < len; t++) begin
         if (t > 0) begin
            @(negedge clk);
            code_sq  = {$urandom, $urandom};
            valid_sq = 16'($urandom);
            load     = (t <= 16) ? (mid_load & 1'($urandom_range(0, 1))) : 1'b0;
            if (t == abort_t) begin
               #2 rst_n = 1'b0;
               #1;
               check($sformatf("async_rst_d0_t%0d", t), {busy0, done0, winc0, byte0}, 11'h0);
               check($sformatf("async_rst_d2_t%0d", t), {busy2, done2, winc2, byte2}, 11'h0);
               @(negedge clk);
               rst_n   = 1'b1;
               load    = 1'b0;
               aborted = 1'b1;
               return;
            end
         end
         @(posedge clk);
         #1;
         check($sformatf("cyc_d0_t%0d", t), {busy0, done0, winc0, byte0}, exp0_q.pop_front());
         check($sformatf("cyc_d2_t%0d", t), {busy2, done2, winc2, byte2}, exp2_q.pop_front());
         if (winc0) got0_q.push_back(byte0);
      end
      load = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [63:0] code;
      logic [15:0] valid;
      bit          mid_load;
      int          abort_t;
      logic [7:0]  hdr;
      logic [63:0] pay;     // payload bytes, first byte in [63:56]
      int          nb;
   } vec_t;

   localparam logic [63:0] CODES = 64'h0123456789ABCDEF;

   vec_t vecs[8];

   initial begin
      bit          ab;
      logic [63:0] pay;
      logic [7:0]  expb;

      vecs[0] = '{CODES, 16'hFFFF, 1'b0, 0,  8'h10, 64'hFEDCBA9876543210, 8};
      vecs[1] = '{CODES, 16'h0005, 1'b0, 0,  8'h02, 64'hFD00000000000000, 1};
      vecs[2] = '{CODES, 16'h0001, 1'b0, 0,  8'h01, 64'hF000000000000000, 1};
      vecs[3] = '{CODES, 16'h0000, 1'b0, 0,  8'h00, 64'h0,                0};
      vecs[4] = '{CODES, 16'h8001, 1'b0, 0,  8'h02, 64'hF000000000000000, 1};
      vecs[5] = '{CODES, 16'hFFFF, 1'b1, 0,  8'h10, 64'hFEDCBA9876543210, 8};
      vecs[6] = '{CODES, 16'hFFFF, 1'b0, 21, 8'h10, 64'hFEDCBA9876543210, 8};
      vecs[7] = '{CODES, 16'hFFFF, 1'b0, 0,  8'h10, 64'hFEDCBA9876543210, 8};

      rst_n    = 1'b0;
      load     = 1'b0;
      code_sq  = '0;
      valid_sq = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_d0", {busy0, done0, winc0, byte0}, 11'h0);
      check("reset_d2", {busy2, done2, winc2, byte2}, 11'h0);
      check("reset_state_d0", state0, 3'd0);
      check("reset_state_d2", state2, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table frames, issued back to back so each load lands right after done falls.
      for (int v = 0; v < 8; v++) begin
         run_frame(vecs[v].code, vecs[v].valid, vecs[v].mid_load, vecs[v].abort_t, ab);
         if (!ab) begin
            pay = vecs[v].pay;
            check($sformatf("vec%0d_nbytes", v), got0_q.size(), vecs[v].nb + 1);
            for (int j = 0; j < got0_q.size() && j <= vecs[v].nb; j++) begin
               expb = (j == 0) ? vecs[v].hdr : pay[63 - 8*(j-1) -: 8];
               check($sformatf("vec%0d_byte%0d", v, j), got0_q[j], expb);
            end
         end
      end

      // Randomized frames against the model.
      for (int r = 0; r < 14; r++) begin
         logic [15:0] vr;
         vr = (r % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         run_frame({$urandom, $urandom}, vr, 1'($urandom_range(0, 1)), 0, ab);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
